matrix_load_buffer: RTL and testbench

MATRIX_LOAD_BUFFER -- requirements
Module: matrix_load_buffer

---
 rtl/matrix_load_buffer.sv | 112 +++++++++++
 tb/tb_matrix_load_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_load_buffer.sv
// rtl/matrix_load_buffer.sv - ping-pong buffer that assembles a row-major element stream into flat N*N matrices
module matrix_load_buffer #(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          clear,
    input  logic [DATA_WIDTH-1:0]                         in_data,
    input  logic                                          in_valid,
    input  logic                                          in_last,
    output logic                                          in_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] out_flat,
    output logic                                          out_valid,
    input  logic                                          out_done,
    output logic                                          err,
    output logic [7:0]                                    mat_count
);

    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int FW = NN * DATA_WIDTH;
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

    logic [FW-1:0] bank_q [2];
    logic [FW-1:0] bank_d [2];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] elem_cnt_q, elem_cnt_d;
    logic          err_q, err_d;
    logic [7:0]    mat_count_q, mat_count_d;

    logic accept;
    logic at_last;
    logic rel_en;

    // The write bank is only ever full when both banks hold unconsumed matrices.
    assign in_ready  = ~full_q[wr_bank_q] & ~clear;
    assign accept    = in_valid & in_ready;
    assign at_last   = (elem_cnt_q == LAST_IDX);
    assign rel_en    = out_done & full_q[rd_bank_q];

    assign out_valid = full_q[rd_bank_q];
    assign out_flat  = bank_q[rd_bank_q];
    assign err       = err_q;
    assign mat_count = mat_count_q;

    always_comb begin
        bank_d      = bank_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        elem_cnt_d  = elem_cnt_q;
        err_d       = 1'b0;
        mat_count_d = mat_count_q;

        if (clear) begin
            full_d     = 2'b00;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            elem_cnt_d = '0;
        end else begin
            if (rel_en) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                mat_count_d       = mat_count_q + 8'd1;
            end
            if (accept) begin
                // Element 0 lands in the most significant slot of the flat word.
                for (int k = 0; k < NN; k++) begin
                    if (elem_cnt_q == CW'(k)) begin
                        bank_d[wr_bank_q][FW-DATA_WIDTH*k-1 -: DATA_WIDTH] = in_data;
                    end
                end
                if (at_last) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    elem_cnt_d        = '0;
                    err_d             = ~in_last;
                end else if (in_last) begin
                    elem_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    elem_cnt_d = elem_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            elem_cnt_q  <= '0;
            err_q       <= 1'b0;
            mat_count_q <= 8'd0;
        end else begin
            bank_q      <= bank_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            elem_cnt_q  <= elem_cnt_d;
            err_q       <= err_d;
            mat_count_q <= mat_count_d;
        end
    end

endmodule

// File: tb/tb_matrix_load_buffer.sv
// tb/tb_matrix_load_buffer.sv - randomized and directed bench for matrix_load_buffer with a queue-based reference model
module tb_matrix_load_buffer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int NN = N * N;
    localparam int FW = NN * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [FW-1:0] out_flat;
    logic          out_valid;
    logic          out_done;
    logic          err;
    logic [7:0]    mat_count;

    matrix_load_buffer #(.MATRIX_SIZE(N), .DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_flat  (out_flat),
        .out_valid (out_valid),
        .out_done  (out_done),
        .err       (err),
        .mat_count (mat_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two completed matrices plus the one being assembled.
    logic [FW-1:0] mq[$];
    logic [FW-1:0] m_cur = '0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic [7:0]    m_mc  = 8'd0;
    bit            m_rdy;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_cnt = 0;
            m_err = 1'b0;
            m_mc  = 8'd0;
        end else begin
            m_err = 1'b0;
            if (clear) begin
                mq.delete();
                m_cnt = 0;
            end else begin
                m_rdy = (mq.size() < 2);
                if (out_done && mq.size() > 0) begin
                    void'(mq.pop_front());
                    m_mc = m_mc + 8'd1;
                end
                if (in_valid && m_rdy) begin
                    m_cur = {m_cur[FW-W-1:0], in_data};
                    if (m_cnt == NN - 1) begin
                        mq.push_back(m_cur);
                        m_cnt = 0;
                        m_err = !in_last;
                    end else if (in_last) begin
                        m_cnt = 0;
                        m_err = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("in_ready", in_ready, (mq.size() < 2) && !clear);
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) chk("out_flat", out_flat, mq[0]);
            chk("err", err, m_err);
            chk("mat_count", mat_count, m_mc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            out_done = 1'b0;
            clear    = 1'b0;
            in_data  = W'($urandom);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input bit last, input bit dn);
        int waits;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        out_done = dn;
        clear    = 1'b0;
        #1;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            out_done = 1'b0;
            #1;
            waits++;
        end
        if (waits >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
    endtask

    task automatic push_mat(input logic [W-1:0] base);
        for (int i = 0; i < NN; i++) push(base + W'(i), i == NN - 1, 1'b0);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
        out_done = 1'b1;
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_done = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_done = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        #1;
        chk("rst_flat", out_flat, '0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_count", mat_count, 8'd0);

        // Single matrix, continuous stream
        for (int i = 0; i < NN; i++) push(W'(i + 1), i == NN - 1, 1'b0);
        idle(1); #1;
        chk("m034_valid", out_valid, 1'b1);
        chk("m034_flat", out_flat, 128'h0102030405060708090A0B0C0D0E0F10);

        // Three back-to-back matrices with no consumer
        do_reset();
        for (int i = 0; i < 2 * NN; i++)
            push((i < NN) ? W'(8'h20 + i) : W'(8'h40 + i - NN), (i == NN - 1) || (i == 2 * NN - 1), 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h60; in_last = 1'b0;
        #1;
        chk("m035_stall", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("m035_hold", out_flat, 128'h202122232425262728292A2B2C2D2E2F);
        @(negedge clk);
        out_done = 1'b1;
        @(negedge clk);
        out_done = 1'b0;
        #1;
        chk("m035_next", out_flat, 128'h404142434445464748494A4B4C4D4E4F);
        chk("m035_ready", in_ready, 1'b1);
        chk("m035_count", mat_count, 8'd1);
        for (int i = 1; i < NN; i++) push(W'(8'h60 + i), i == NN - 1, 1'b0);
        idle(2);

        // Early in_last
        do_reset();
        for (int i = 0; i < 5; i++) push(W'(8'h11 + i), i == 4, 1'b0);
        idle(1); #1;
        chk("m036_err", err, 1'b1);
        chk("m036_valid", out_valid, 1'b0);
        push_mat(8'h30);
        idle(2);

        // Ignored done, then a matrix missing in_last
        do_reset();
        pulse_done(); #1;
        chk("m037_ign", mat_count, 8'd0);
        for (int i = 0; i < NN; i++) push(W'(8'h50 + i), 1'b0, 1'b0);
        idle(1); #1;
        chk("m037_err", err, 1'b1);
        chk("m037_valid", out_valid, 1'b1);
        idle(1); #1;
        chk("m037_once", err, 1'b0);

        // Commit and release in the same cycle
        do_reset();
        for (int i = 0; i < NN; i++) push(W'(i + 1), i == NN - 1, 1'b0);
        for (int i = 0; i < NN; i++) push(W'(8'h81 + i), i == NN - 1, i == NN - 1);
        idle(1); #1;
        chk("m038_valid", out_valid, 1'b1);
        chk("m038_flat", out_flat, 128'h8182838485868788898A8B8C8D8E8F90);
        chk("m038_count", mat_count, 8'd1);

        // Reset and clear mid-fill
        do_reset();
        for (int i = 0; i < 7; i++) push(W'(i), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_mat(8'hA0);
        idle(1); #1;
        chk("m039_rst", out_flat, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        pulse_done();
        for (int i = 0; i < 9; i++) push(W'(8'hB0 + i), 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 8'hEE;
        #1;
        chk("m039_clr_ready", in_ready, 1'b0);
        push_mat(8'hC0);
        idle(1); #1;
        chk("m039_clr", out_flat, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        chk("m039_count", mat_count, 8'd1);

        // Randomized traffic: slow consumer first, then a fast one
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            in_last  = (m_cnt == NN - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 40) == 0);
            out_done = (c < 1500) ? ($urandom_range(0, 12) == 0) : ($urandom_range(0, 2) == 0);
            clear    = ($urandom_range(0, 150) == 0);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
